muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in the execute stage.
//  Accepts one op at a time, iterates a shift-add / restoring-subtract step for XLEN cycles, then returns one result.
//  busy drives the hazard unit: it stalls fetch/decode/execute while busy=1.
//  Results merge into the ALUResult mux in the same slot as ALUControl-selected ops.
// PARAMETERS
//  XLEN    32  operand/result width
//  CNT_W   $clog2(XLEN)  iteration counter width (derived, not overridden)
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     asynchronous, active-high reset
//  start     in   1     issue request; sampled only in IDLE
//  funct3    in   3     M-op select (000 MUL .. 111 REMU, RV32M encoding)
//  srcA      in   XLEN  rs1 operand; captured on accepted start
//  srcB      in   XLEN  rs2 operand; captured on accepted start
//  flush     in   1     pipeline flush; abandons the in-flight op
//  busy      out  1     1 while in RUN
//  done      out  1     one-cycle pulse; result valid
//  result    out  XLEN  registered result; held until the next done
// BEHAVIOUR
//  - Reset (async): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE -start-> RUN. On the fast path, IDLE -start-> DONE.
//    RUN with counter==XLEN-1 -> DONE.
//    DONE -> IDLE unconditionally.
//  - Accept: start=1 in IDLE at edge k latches funct3, srcA, srcB.
//    start in RUN or DONE is ignored; it is not queued.
//  - Normal latency: RUN occupies cycles k+1..k+XLEN. DONE (done=1, result valid) is cycle k+XLEN+1 (33 for XLEN=32).
//  - Signed ops: take absolute values on entry. Apply sign fix when DONE is entered.
//    MUL/MULH* use a 2*XLEN product; MUL returns [XLEN-1:0], MULH* return [2XLEN-1:XLEN].
//    MULHSU treats srcA as signed and srcB as unsigned.
//    DIV/REM truncate toward zero; the remainder takes the dividend's sign.
//  - Fast path (IDLE->DONE, done at cycle k+1):
//    divide by zero: DIV/DIVU=all ones, REM/REMU=srcA;
//    signed overflow srcA=0x80000000, srcB=-1: DIV=0x80000000, REM=0.
//  - Flush: flush=1 in RUN or DONE forces IDLE at the next edge, with no done and result unchanged.
//    flush has priority over counter termination.
//    flush and start together in IDLE: flush wins, the op is not accepted.
//  - busy=0 in the DONE cycle. The hazard unit releases the stall there and the result is consumed that cycle.
//  - Back-to-back: a new start is earliest in the cycle after DONE (IDLE).
//  - Reset mid-operation returns to IDLE immediately, with outputs as at reset.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//    MUL/MULH/MULHSU/MULHU are computed in one step with the '*' operator and take the fast path (done at k+1).
//    DIV/REM are unchanged.
//  MULDIV_FAST_MUL_EN undefined:
//    all multiplies iterate XLEN cycles (done at k+XLEN+1); no '*' is inferred.
// STRUCTURE
//  muldiv_pkg:
//    typedef enum logic[2:0] muldiv_op_e (MUL..REMU);
//    typedef enum logic[1:0] muldiv_state_e (IDLE, RUN, DONE);
//    localparam MULDIV_XLEN=32.
//  Sub-module muldiv_iter_step: combinational single iteration.
//    multiply: conditional add + shift;
//    divide: trial subtract + shift, quotient bit.
//    Instantiated once and driven by the FSM registers.
// TESTING
//  MUL 7 * -3 -> result 0xFFFFFFEB; done at cycle 33 (1 with FAST_MUL); busy=1 in cycles 1..32.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
//  flush at cycle 10 of DIV -> IDLE at cycle 11, no done; result keeps its previous value.
//    Then start MUL 3*4 -> 12 with normal latency.
//  rst asserted at cycle 5 of RUN -> busy=0, done=0, result=0 immediately.
//    start during RUN is ignored: exactly one done per accepted start.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Package: muldiv_pkg
// Shared types for the RV32M multiply/divide sequencer.
//   muldiv_op_e    : funct3 encoding of the eight M-extension operations
//   muldiv_state_e : sequencer FSM states (IDLE, RUN, DONE)
//   MULDIV_XLEN    : default operand/result width
// Optional build macro used by the sequencer: MULDIV_FAST_MUL_EN
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// Module: muldiv_iter_step
// One combinational iteration of the sequencer datapath. The {hi, lo} pair
// is the working register; operand is the multiplicand or the divisor.
//   is_div   in  : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi, lo   in  : current working register halves
//   operand  in  : multiplicand (multiply) or divisor (divide), magnitude
//   hi_next  out : next upper half (partial product / partial remainder)
//   lo_next  out : next lower half (multiplier bits / quotient bits)
module muldiv_iter_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift the whole {carry, hi, lo} right so the next multiplier bit
    // reaches lo[0]. Divide: shift the next dividend bit into the partial
    // remainder and keep the trial difference only if it did not go negative;
    // the quotient bit enters at lo[0] as the dividend bits leave at the top.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        shifted = {hi, lo[XLEN-1]};
        trial   = shifted - {1'b0, operand};
        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            if (!trial[XLEN]) begin
                hi_next = trial[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Module: muldiv_sequencer
// Multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit for the
// execute stage. Works on operand magnitudes for XLEN iterations and applies
// the sign correction as the result is registered on entry to DONE.
// Divide by zero and signed overflow skip the iteration (done one cycle
// after acceptance).
// Build option: MULDIV_FAST_MUL_EN - multiplies use a single '*' and take
// the one-cycle path; without it every multiply iterates.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start, funct3   : issue request and M-op select (sampled only in IDLE)
//   srcA, srcB      : rs1/rs2 operands, captured on an accepted start
//   flush           : abandons the in-flight op, no done is produced
//   busy            : high while iterating (drives the hazard stall)
//   done            : one-cycle pulse, result valid
//   result          : registered result, held until the next done
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_e   state;
    muldiv_op_e      op_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q;
    logic            neg_main_q, neg_rem_q;

    muldiv_op_e      op_in;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf, fast_hit;
    logic [XLEN-1:0] fast_val;

    logic [XLEN-1:0]   hi_next, lo_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   final_val;

    assign op_in = muldiv_op_e'(funct3);

    // Operand conditioning at acceptance: MULHSU only treats srcA as signed,
    // and the unsigned ops never negate.
    assign a_neg = srcA[XLEN-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign b_neg = srcB[XLEN-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
    assign a_mag = a_neg ? -srcA : srcA;
    assign b_mag = b_neg ? -srcB : srcB;

    assign div_by_zero = funct3[2] && (srcB == '0);
    assign div_ovf     = (op_in inside {OP_DIV, OP_REM})
                         && (srcA == {1'b1, {(XLEN-1){1'b0}}})
                         && (srcB == '1);

    // Results that need no iteration. funct3[1] separates REM/REMU from
    // DIV/DIVU; the multiply branch exists only in the fast-multiply build.
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, prod_fast;
    assign ext_a     = {{XLEN{a_neg ? 1'b1 : 1'b0}}, srcA};
    assign ext_b     = {{XLEN{b_neg ? 1'b1 : 1'b0}}, srcB};
    assign prod_fast = ext_a * ext_b;
    assign fast_hit  = !funct3[2] || div_by_zero || div_ovf;
`else
    assign fast_hit  = div_by_zero || div_ovf;
`endif

    always_comb begin
        fast_val = '0;
        if (div_by_zero) begin
            fast_val = funct3[1] ? srcA : '1;
        end else if (div_ovf) begin
            fast_val = funct3[1] ? '0 : srcA;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!funct3[2]) begin
            fast_val = (op_in == OP_MUL) ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
        end
`endif
    end

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (opnd_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Sign correction applied to the output of the final iteration, so the
    // registered result is already final in the DONE cycle.
    always_comb begin
        prod_fix  = neg_main_q ? -{hi_next, lo_next} : {hi_next, lo_next};
        final_val = prod_fix[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:           final_val = prod_fix[XLEN-1:0];
            OP_DIV, OP_DIVU:  final_val = neg_main_q ? -lo_next : lo_next;
            OP_REM, OP_REMU:  final_val = neg_rem_q ? -hi_next : hi_next;
            default:          final_val = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // Sequencer FSM. Flush beats both a new start in IDLE and the final
    // iteration in RUN; a flushed op leaves result untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_MUL;
            cnt        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q <= op_in;
                        if (fast_hit) begin
                            result <= fast_val;
                            state  <= ST_DONE;
                        end else begin
                            hi_q       <= '0;
                            lo_q       <= a_mag;
                            opnd_q     <= b_mag;
                            neg_main_q <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            cnt        <= '0;
                            state      <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        hi_q <= hi_next;
                        lo_q <= lo_next;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_W'(XLEN-1)) begin
                            result <= final_val;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
